pipeline_ctrl: RTL

Central pipeline controller for the five-stage core. It sequences the IF/ID/EX/MEM pipeline registers by generating per-stage stall and flush signals and the redirect PC. It resolves load hazards reported by the decoder, branch redirects, bus wait states, exceptions and exception return. It also owns the control-register file that the decoder reads through creg_rd_addr/creg_rd_data, including the exe_mode bit.

---
 rtl/pipeline_ctrl_pkg.sv | 44 ++++
 rtl/pipeline_ctrl_creg_file.sv | 70 +++++++
 rtl/pipeline_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline controller: creg addresses, ctrl ops,
// exception codes, STATUS bit positions and the controller FSM states.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_WRCR = 2'd1,
    OP_EXRT = 2'd2,
    OP_RSVD = 2'd3
  } ctrl_op_e;

  typedef enum logic [2:0] {
    EXC_NONE     = 3'd0,
    EXC_EXT_INT  = 3'd1,
    EXC_UNDEF    = 3'd2,
    EXC_OVERFLOW = 3'd3,
    EXC_MISALIGN = 3'd4,
    EXC_TRAP     = 3'd5,
    EXC_PRIV     = 3'd6
  } exc_code_e;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [4:0] CR_STATUS     = 5'd0;
  localparam logic [4:0] CR_PRE_STATUS = 5'd1;
  localparam logic [4:0] CR_EPC        = 5'd2;
  localparam logic [4:0] CR_EXP_VECTOR = 5'd3;
  localparam logic [4:0] CR_CAUSE      = 5'd4;
  localparam logic [4:0] CR_INT_MASK   = 5'd5;
  localparam logic [4:0] CR_IRQ        = 5'd6;

  localparam int ST_EXE_MODE = 0;
  localparam int ST_INT_EN   = 1;

  typedef struct packed {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } creg_wr_t;

endpackage

// File: rtl/pipeline_ctrl_creg_file.sv
// Control-register storage with a combinational read mux and the
// exception-entry / exception-return update paths.
module creg_file
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXP_VECTOR_RST = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  input  creg_wr_t    wr,
  input  logic        exc_en,
  input  logic [31:0] exc_pc,
  input  logic [2:0]  exc_code,
  input  logic        ret_en,
  input  logic [7:0]  irq,
  output logic [1:0]  status,
  output logic [7:0]  int_mask,
  output logic [31:0] epc,
  output logic [31:0] exp_vector
);

  logic [1:0] pre_status;
  logic [2:0] cause;

  // Exception entry outranks return, which outranks an explicit write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status     <= '0;
      pre_status <= '0;
      epc        <= '0;
      exp_vector <= EXP_VECTOR_RST;
      cause      <= '0;
      int_mask   <= 8'hFF;
    end else if (exc_en) begin
      epc        <= exc_pc;
      cause      <= exc_code;
      pre_status <= status;
      status     <= '0;
    end else if (ret_en) begin
      status <= pre_status;
    end else if (wr.en) begin
      case (wr.addr)
        CR_STATUS:     status     <= wr.data[1:0];
        CR_PRE_STATUS: pre_status <= wr.data[1:0];
        CR_EPC:        epc        <= wr.data;
        CR_EXP_VECTOR: exp_vector <= wr.data;
        CR_CAUSE:      cause      <= wr.data[2:0];
        CR_INT_MASK:   int_mask   <= wr.data[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CR_STATUS:     rd_data = {30'd0, status};
      CR_PRE_STATUS: rd_data = {30'd0, pre_status};
      CR_EPC:        rd_data = epc;
      CR_EXP_VECTOR: rd_data = exp_vector;
      CR_CAUSE:      rd_data = {29'd0, cause};
      CR_INT_MASK:   rd_data = {24'd0, int_mask};
      CR_IRQ:        rd_data = {24'd0, irq};
      default:       rd_data = '0;
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: per-stage stall/flush generation, redirect PC,
// BOOT/RUN sequencing and interrupt detection over the creg file.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter logic [31:0] EXP_VECTOR_RST = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_busy,
  input  logic        mem_busy,
  input  logic        ld_hazard,
  input  logic        br_taken,
  input  logic [7:0]  irq,
  input  logic        mem_en,
  input  logic [31:0] mem_pc,
  input  logic [1:0]  mem_ctrl_op,
  input  logic [4:0]  mem_dst_addr,
  input  logic [31:0] mem_out,
  input  logic [2:0]  mem_exp_code,
  input  logic [4:0]  creg_rd_addr,
  output logic [31:0] creg_rd_data,
  output logic        exe_mode,
  output logic        int_detect,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic [31:0] new_pc
);

  state_e      state;
  logic        stall, run, exc_ev, ret_ev, wr_ev;
  logic [1:0]  status;
  logic [7:0]  int_mask;
  logic [31:0] epc, exp_vector;
  creg_wr_t    wr;

  assign stall  = if_busy | mem_busy;
  assign run    = reset && (state == ST_RUN) && !stall;
  assign exc_ev = run && mem_en && (mem_exp_code != EXC_NONE);
  assign ret_ev = run && mem_en && !exc_ev && (mem_ctrl_op == OP_EXRT);
  assign wr_ev  = run && mem_en && !exc_ev && (mem_ctrl_op == OP_WRCR);

  assign wr.en   = wr_ev;
  assign wr.addr = mem_dst_addr;
  assign wr.data = mem_out;

  creg_file #(.EXP_VECTOR_RST(EXP_VECTOR_RST)) u_creg (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (creg_rd_addr),
    .rd_data    (creg_rd_data),
    .wr         (wr),
    .exc_en     (exc_ev),
    .exc_pc     (mem_pc),
    .exc_code   (mem_exp_code),
    .ret_en     (ret_ev),
    .irq        (irq),
    .status     (status),
    .int_mask   (int_mask),
    .epc        (epc),
    .exp_vector (exp_vector)
  );

  assign exe_mode = status[ST_EXE_MODE];

  // BOOT waits out a stall so its redirect is never lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_BOOT;
      int_detect <= 1'b0;
    end else begin
      int_detect <= status[ST_INT_EN] & (|(irq & ~int_mask));
      if (state == ST_BOOT && !stall) state <= ST_RUN;
    end
  end

  // Control outputs stay quiet while reset is held.
  assign if_stall  = reset & (stall | ld_hazard);
  assign id_stall  = reset & (stall | ld_hazard);
  assign ex_stall  = reset & stall;
  assign mem_stall = reset & stall;

  always_comb begin
    {if_flush, id_flush, ex_flush, mem_flush} = '0;
    new_pc = RESET_VECTOR;
    if (reset && !stall) begin
      if (state == ST_BOOT) begin
        if_flush = 1'b1;
        new_pc   = RESET_VECTOR;
      end else if (exc_ev || ret_ev || wr_ev) begin
        {if_flush, id_flush, ex_flush, mem_flush} = '1;
        new_pc = exc_ev ? exp_vector : (ret_ev ? epc : mem_pc + 32'd4);
      end else if (br_taken) begin
        if_flush = 1'b1;
      end else if (ld_hazard) begin
        id_flush = 1'b1;
      end
    end
  end

endmodule
